// File: rtl/instruction_encoder_loader.sv
// rtl/instruction_encoder_loader.sv - encodes mnemonic commands into MIPS words and writes them sequentially to instruction memory
module instruction_encoder_loader #(
  parameter int ADDR_W    = 32,
  parameter int MAX_WORDS = 256,
  parameter int CNT_W     = 9
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic              Abort,
  input  logic              CmdValid,
  output logic              CmdReady,
  input  logic [5:0]        CmdOp,
  input  logic [4:0]        CmdRs,
  input  logic [4:0]        CmdRt,
  input  logic [4:0]        CmdRd,
  input  logic [4:0]        CmdShamt,
  input  logic [25:0]       CmdImm,
  input  logic              CmdLast,
  output logic              IMemWrite,
  output logic [ADDR_W-1:0] IMemAddr,
  output logic [31:0]       IMemWriteData,
  output logic [CNT_W-1:0]  WordCount,
  output logic              Busy,
  output logic              Done,
  output logic              Error
);

  typedef enum logic [1:0] {Idle, Run, Finish} state_t;

  state_t            state;
  logic [ADDR_W-1:0] baseAddr;
  logic [CNT_W:0]    effCount;
  logic              accept;
  logic              opLegal;
  logic [31:0]       encWord;

  function automatic logic [31:0] rType(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh, input logic [5:0] funct);
    return {op, rs, rt, rd, sh, funct};
  endfunction

  function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // A write registered this cycle has not reached WordCount yet, so count it here
  // to keep capacity checks and address generation correct on back-to-back accepts.
  assign effCount = {1'b0, WordCount} + (CNT_W+1)'(IMemWrite);
  assign CmdReady = (state == Run) && (effCount < (CNT_W+1)'(MAX_WORDS)) && !Abort;
  assign accept   = CmdValid && CmdReady;
  assign Busy     = (state != Idle);

  always_comb begin
    encWord = '0;
    opLegal = 1'b1;
    case (CmdOp)
      6'd0:  encWord = '0;
      6'd1:  encWord = rType(6'd0, CmdRs, CmdRt, CmdRd, 5'd0, 6'd32);
      6'd2:  encWord = rType(6'd0, CmdRs, CmdRt, CmdRd, 5'd0, 6'd33);
      6'd3:  encWord = rType(6'd0, CmdRs, CmdRt, CmdRd, 5'd0, 6'd34);
      6'd4:  encWord = rType(6'd0, CmdRs, CmdRt, CmdRd, 5'd0, 6'd35);
      6'd5:  encWord = rType(6'd0, CmdRs, CmdRt, CmdRd, 5'd0, 6'd36);
      6'd6:  encWord = rType(6'd0, CmdRs, CmdRt, CmdRd, 5'd0, 6'd37);
      6'd7:  encWord = rType(6'd0, CmdRs, CmdRt, CmdRd, 5'd0, 6'd38);
      6'd8:  encWord = rType(6'd0, CmdRs, CmdRt, CmdRd, 5'd0, 6'd39);
      6'd9:  encWord = rType(6'd0, CmdRs, CmdRt, CmdRd, 5'd0, 6'd42);
      6'd10: encWord = rType(6'd0, CmdRs, CmdRt, CmdRd, 5'd0, 6'd43);
      6'd11: encWord = rType(6'd0, 5'd0, CmdRt, CmdRd, CmdShamt, 6'd0);
      6'd12: encWord = rType(6'd0, CmdRs, CmdRt, CmdRd, 5'd0, 6'd4);
      6'd13: encWord = rType(6'd0, 5'd1, CmdRt, CmdRd, CmdShamt, 6'd2);
      6'd14: encWord = rType(6'd0, CmdRs, CmdRt, CmdRd, 5'd1, 6'd6);
      6'd15: encWord = rType(6'd0, CmdRs, CmdRt, CmdRd, 5'd0, 6'd10);
      6'd16: encWord = rType(6'd0, CmdRs, 5'd0, 5'd0, 5'd0, 6'd8);
      6'd17: encWord = iType(6'd8,  CmdRs, CmdRt, CmdImm[15:0]);
      6'd18: encWord = iType(6'd9,  CmdRs, CmdRt, CmdImm[15:0]);
      6'd19: encWord = iType(6'd12, CmdRs, CmdRt, CmdImm[15:0]);
      6'd20: encWord = iType(6'd13, CmdRs, CmdRt, CmdImm[15:0]);
      6'd21: encWord = iType(6'd14, CmdRs, CmdRt, CmdImm[15:0]);
      6'd22: encWord = iType(6'd10, CmdRs, CmdRt, CmdImm[15:0]);
      6'd23: encWord = iType(6'd11, CmdRs, CmdRt, CmdImm[15:0]);
      6'd24: encWord = iType(6'd15, 5'd0,  CmdRt, CmdImm[15:0]);
      6'd25: encWord = iType(6'd35, CmdRs, CmdRt, CmdImm[15:0]);
      6'd26: encWord = iType(6'd43, CmdRs, CmdRt, CmdImm[15:0]);
      6'd27: encWord = iType(6'd4,  CmdRs, CmdRt, CmdImm[15:0]);
      6'd28: encWord = iType(6'd5,  CmdRs, CmdRt, CmdImm[15:0]);
      6'd29: encWord = iType(6'd1,  CmdRs, 5'd0,  CmdImm[15:0]);
      6'd30: encWord = iType(6'd1,  CmdRs, 5'd1,  CmdImm[15:0]);
      6'd31: encWord = iType(6'd7,  CmdRs, 5'd0,  CmdImm[15:0]);
      6'd32: encWord = {6'd2, CmdImm};
      6'd33: encWord = {6'd3, CmdImm};
      6'd34: encWord = rType(6'd28, CmdRs, CmdRt, CmdRd, 5'd0, 6'd33);
      6'd35: encWord = rType(6'd28, CmdRs, CmdRt, CmdRd, 5'd0, 6'd32);
      6'd36: encWord = rType(6'd28, CmdRs, CmdRt, CmdRd, 5'd0, 6'd2);
      default: opLegal = 1'b0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= Idle;
      baseAddr      <= '0;
      IMemWrite     <= 1'b0;
      IMemAddr      <= '0;
      IMemWriteData <= '0;
      WordCount     <= '0;
      Done          <= 1'b0;
      Error         <= 1'b0;
    end else begin
      IMemWrite <= 1'b0;
      Done      <= 1'b0;
      if (IMemWrite)
        WordCount <= WordCount + CNT_W'(1);
      if (Abort) begin
        state <= Idle;
      end else begin
        case (state)
          Idle: if (Start) begin
            state     <= Run;
            baseAddr  <= BaseAddr & ~ADDR_W'(3);
            WordCount <= '0;
            Error     <= 1'b0;
          end
          Run: if (accept) begin
            if (opLegal) begin
              IMemWrite     <= 1'b1;
              IMemAddr      <= baseAddr + (ADDR_W'(effCount) << 2);
              IMemWriteData <= encWord;
            end else begin
              Error <= 1'b1;
            end
            if (CmdLast) begin
              state <= Finish;
              Done  <= 1'b1;
            end
          end
          Finish: state <= Idle;
          default: state <= Idle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// tb/tb_instruction_encoder_loader.sv - directed self-checking bench for instruction_encoder_loader
module tb_instruction_encoder_loader;

  logic        Clk = 1'b0;
  logic        Reset, Start, Abort, CmdValid, CmdLast;
  logic [31:0] BaseAddr;
  logic [5:0]  CmdOp;
  logic [4:0]  CmdRs, CmdRt, CmdRd, CmdShamt;
  logic [25:0] CmdImm;
  logic        CmdReady, IMemWrite, Busy, Done, Error;
  logic [31:0] IMemAddr, IMemWriteData;
  logic [2:0]  WordCount;

  int nCmp = 0;
  int nFail = 0;
  int nw;
  logic sawDone;

  always #5 Clk = ~Clk;

  instruction_encoder_loader #(.ADDR_W(32), .MAX_WORDS(4), .CNT_W(3)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .BaseAddr(BaseAddr), .Abort(Abort),
    .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdOp(CmdOp), .CmdRs(CmdRs),
    .CmdRt(CmdRt), .CmdRd(CmdRd), .CmdShamt(CmdShamt), .CmdImm(CmdImm),
    .CmdLast(CmdLast), .IMemWrite(IMemWrite), .IMemAddr(IMemAddr),
    .IMemWriteData(IMemWriteData), .WordCount(WordCount), .Busy(Busy),
    .Done(Done), .Error(Error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic setCmd(input int op, input int rs, input int rt, input int rd,
                        input int sh, input int imm, input logic last);
    CmdOp    = 6'(op);
    CmdRs    = 5'(rs);
    CmdRt    = 5'(rt);
    CmdRd    = 5'(rd);
    CmdShamt = 5'(sh);
    CmdImm   = 26'(imm);
    CmdLast  = last;
    CmdValid = 1'b1;
  endtask

  task automatic startSession(input logic [31:0] base);
    BaseAddr = base;
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic checkWrite(input string tag, input logic [31:0] addr, input logic [31:0] data);
    check({tag, "_we"}, 32'(IMemWrite), 32'd1);
    check({tag, "_addr"}, IMemAddr, addr);
    check({tag, "_data"}, IMemWriteData, data);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Abort = 1'b0; BaseAddr = '0;
    CmdValid = 1'b0; CmdLast = 1'b0; CmdOp = '0; CmdRs = '0; CmdRt = '0;
    CmdRd = '0; CmdShamt = '0; CmdImm = '0;
    tick(); tick();
    check("rst_we", 32'(IMemWrite), 32'd0);
    check("rst_addr", IMemAddr, 32'd0);
    check("rst_data", IMemWriteData, 32'd0);
    check("rst_cnt", 32'(WordCount), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_err", 32'(Error), 32'd0);
    check("rst_ready", 32'(CmdReady), 32'd0);
    Reset = 1'b0;
    tick();

    // ADD, then illegal op, then a last ADD
    startSession(32'h0);
    check("s1_busy", 32'(Busy), 32'd1);
    setCmd(1, 1, 2, 3, 0, 0, 1'b0);
    check("s1_ready", 32'(CmdReady), 32'd1);
    tick(); CmdValid = 1'b0;
    checkWrite("add0", 32'h0, 32'h00221820);
    check("add0_cnt", 32'(WordCount), 32'd0);
    tick();
    check("add0_idle_we", 32'(IMemWrite), 32'd0);
    check("add0_cnt1", 32'(WordCount), 32'd1);
    setCmd(40, 1, 2, 3, 0, 0, 1'b0);
    tick(); CmdValid = 1'b0;
    check("ill_we", 32'(IMemWrite), 32'd0);
    check("ill_err", 32'(Error), 32'd1);
    check("ill_cnt", 32'(WordCount), 32'd1);
    setCmd(1, 4, 5, 6, 0, 0, 1'b1);
    tick(); CmdValid = 1'b0;
    checkWrite("add1", 32'h4, 32'h00853020);
    check("add1_done", 32'(Done), 32'd1);
    tick();
    check("s1_done_off", 32'(Done), 32'd0);
    check("s1_busy_off", 32'(Busy), 32'd0);
    check("s1_cnt", 32'(WordCount), 32'd2);
    check("s1_err_sticky", 32'(Error), 32'd1);

    // back-to-back stream at 0x100
    startSession(32'h100);
    check("s2_err_clr", 32'(Error), 32'd0);
    setCmd(17, 0, 1, 0, 0, 5, 1'b0);
    tick();
    checkWrite("addi", 32'h100, 32'h20010005);
    setCmd(26, 29, 2, 0, 0, 4, 1'b0);
    tick();
    checkWrite("sw", 32'h104, 32'hAFA20004);
    check("sw_cnt", 32'(WordCount), 32'd1);
    setCmd(27, 1, 2, 0, 0, 32'hFFFF, 1'b0);
    tick();
    checkWrite("beq", 32'h108, 32'h1022FFFF);
    setCmd(32, 0, 0, 0, 0, 32'h10, 1'b1);
    tick(); CmdValid = 1'b0;
    checkWrite("j", 32'h10C, 32'h08000010);
    check("j_done", 32'(Done), 32'd1);
    tick();
    check("s2_done_off", 32'(Done), 32'd0);
    check("s2_busy", 32'(Busy), 32'd0);
    check("s2_cnt", 32'(WordCount), 32'd4);

    // field-override encodings
    startSession(32'h1000);
    setCmd(11, 7, 2, 3, 4, 0, 1'b0);
    tick();
    checkWrite("sll", 32'h1000, 32'h00021900);
    setCmd(13, 9, 5, 6, 3, 0, 1'b0);
    tick();
    checkWrite("rotr", 32'h1004, 32'h002530C2);
    setCmd(24, 3, 4, 9, 0, 32'h1234, 1'b0);
    tick();
    checkWrite("lui", 32'h1008, 32'h3C041234);
    setCmd(36, 1, 2, 3, 5, 0, 1'b1);
    tick(); CmdValid = 1'b0;
    checkWrite("mul", 32'h100C, 32'h70221802);
    tick();

    startSession(32'h2000);
    setCmd(16, 31, 2, 3, 4, 0, 1'b0);
    tick();
    checkWrite("jr", 32'h2000, 32'h03E00008);
    setCmd(29, 5, 7, 0, 0, 8, 1'b0);
    tick();
    checkWrite("bltz", 32'h2004, 32'h04A00008);
    setCmd(30, 5, 7, 0, 0, 8, 1'b0);
    tick();
    checkWrite("bgez", 32'h2008, 32'h04A10008);
    setCmd(14, 1, 2, 3, 9, 0, 1'b1);
    tick(); CmdValid = 1'b0;
    checkWrite("rotrv", 32'h200C, 32'h00221846);
    tick();

    // capacity limit with unaligned base, then abort
    startSession(32'h203);
    setCmd(0, 3, 3, 3, 3, 32'h3FF, 1'b0);
    nw = 0; sawDone = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (IMemWrite) begin
        check("full_addr", IMemAddr, 32'h200 + 32'(4 * nw));
        check("full_data", IMemWriteData, 32'h0);
        nw++;
      end
      if (Done) sawDone = 1'b1;
    end
    check("full_writes", 32'(nw), 32'd4);
    check("full_ready", 32'(CmdReady), 32'd0);
    check("full_nodone", 32'(sawDone), 32'd0);
    check("full_busy", 32'(Busy), 32'd1);
    check("full_cnt", 32'(WordCount), 32'd4);
    Abort = 1'b1;
    tick();
    Abort = 1'b0; CmdValid = 1'b0;
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_we", 32'(IMemWrite), 32'd0);

    // reset right after an accept
    startSession(32'h40);
    setCmd(1, 1, 2, 3, 0, 0, 1'b0);
    tick(); CmdValid = 1'b0;
    Reset = 1'b1;
    tick();
    check("mrst_we", 32'(IMemWrite), 32'd0);
    check("mrst_addr", IMemAddr, 32'd0);
    check("mrst_data", IMemWriteData, 32'd0);
    check("mrst_cnt", 32'(WordCount), 32'd0);
    check("mrst_busy", 32'(Busy), 32'd0);
    check("mrst_done", 32'(Done), 32'd0);
    check("mrst_err", 32'(Error), 32'd0);
    Reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
